// File: rtl/retire_unit_pkg.sv
// Core-wide design parameters and the types shared by the commit stage.
package cpu_design_params;

  localparam int NUM_A_REGS = 32;
  localparam int ROB_SIZE   = 16;
  localparam int NUM_P_REGS = 48;

  localparam int ARN_W     = $clog2(NUM_A_REGS);
  localparam int PRN_W     = $clog2(NUM_P_REGS);
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);
  localparam int PC_W      = 32;

  typedef logic [ARN_W-1:0]     arn_t;
  typedef logic [PRN_W-1:0]     prn_t;
  typedef logic [PC_W-1:0]      pc_t;
  typedef logic [ROB_IDX_W-1:0] hist_ptr_t;

  // One ROB entry as seen at the head.
  typedef struct packed {
    logic      valid;
    logic      done;
    logic      exception;
    logic      writes_rd;
    prn_t      p_new;
    prn_t      p_old;
    arn_t      rd_arch;
    hist_ptr_t hist_ptr;
    pc_t       pc;
  } rob_data_t;

  // Commit-stage operating mode.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SQUASH  = 2'd1,
    RESTORE = 2'd2
  } retire_state_t;

  // A register to hand back to the free list, if any.
  typedef struct packed {
    logic valid;
    prn_t prn;
  } free_req_t;

  // Architectural register i maps to physical register i out of reset.
  function automatic prn_t arat_reset(input arn_t i);
    return prn_t'(i);
  endfunction

  // Which register an entry releases: p_old on commit, p_new on squash.
  // Writes to r0 never allocated a register, so they release nothing.
  function automatic free_req_t frees_reg(input rob_data_t e, input logic use_new);
    free_req_t r;
    r.valid = e.writes_rd && (e.rd_arch != '0);
    r.prn   = use_new ? e.p_new : e.p_old;
    return r;
  endfunction

endpackage

// File: rtl/retire_unit_fsm.sv
// Mode sequencer of the commit stage: RUN -> SQUASH -> RESTORE -> RUN,
// plus the architectural-index counter that walks the RAT during RESTORE.
module retire_fsm
  import cpu_design_params::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rob_head_valid,
  input  logic          exc_detect,
  output retire_state_t state,
  output arn_t          cnt
);

  retire_state_t state_next;
  arn_t          cnt_next;

  // Next mode and counter value from the current mode and ROB occupancy.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (exc_detect) state_next = SQUASH;
      end
      SQUASH: begin
        // ROB drained: begin streaming the committed map from index 0.
        if (!rob_head_valid) begin
          state_next = RESTORE;
          cnt_next   = '0;
        end
      end
      RESTORE: begin
        cnt_next = cnt + 1'b1;
        if (cnt == arn_t'(NUM_A_REGS - 1)) state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Mode and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: rtl/retire_unit.sv
// In-order commit stage at the ROB head. Retires done entries, frees the
// displaced mapping, keeps the architectural RAT, and on an exception
// squashes the ROB and streams the committed RAT back to rename.
//
// Free-list handshake: a register is transferred in any cycle where
// fl_push_valid && fl_push_ready. fl_push_valid is only raised together
// with rob_pop, so a push and the pop of its entry always happen in the
// same cycle and a stalled head produces no push request.
module retire_unit
  import cpu_design_params::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rob_head_valid,
  input  rob_data_t rob_head,
  output logic      rob_pop,
  output logic      fl_push_valid,
  output prn_t      fl_push_prn,
  input  logic      fl_push_ready,
  output logic      flush,
  output logic      exc_valid,
  output pc_t       exc_pc,
  output logic      rest_valid,
  output arn_t      rest_arch,
  output prn_t      rest_prn,
  output logic      commit_valid,
  output arn_t      commit_arch,
  output prn_t      commit_prn
);

  retire_state_t state;
  arn_t          cnt;
  prn_t          arat [NUM_A_REGS];

  logic      head_live;
  logic      exc_detect;
  free_req_t run_free;
  free_req_t sq_free;

  // hist_ptr belongs to rename's branch bookkeeping; commit has no use for it.
  logic unused_hist;
  assign unused_hist = ^rob_head.hist_ptr;

  assign head_live  = rob_head_valid && rob_head.valid;
  assign run_free   = frees_reg(rob_head, 1'b0);
  assign sq_free    = frees_reg(rob_head, 1'b1);
  assign exc_detect = (state == RUN) && head_live && rob_head.done && rob_head.exception;
  assign flush      = (state != RUN);

  retire_fsm u_fsm (
    .clk            (clk),
    .rst            (rst),
    .rob_head_valid (rob_head_valid),
    .exc_detect     (exc_detect),
    .state          (state),
    .cnt            (cnt)
  );

  // Same-cycle pop/push decision for the head entry.
  always_comb begin
    rob_pop       = 1'b0;
    fl_push_valid = 1'b0;
    fl_push_prn   = '0;
    case (state)
      RUN: begin
        if (head_live && rob_head.done && !rob_head.exception) begin
          if (!run_free.valid) begin
            rob_pop = 1'b1;
          end else if (fl_push_ready) begin
            rob_pop       = 1'b1;
            fl_push_valid = 1'b1;
            fl_push_prn   = run_free.prn;
          end
        end
      end
      SQUASH: begin
        // Squashed entries are dropped whether or not they completed;
        // their speculative p_new goes back to the free list.
        if (rob_head_valid) begin
          if (!(rob_head.valid && sq_free.valid)) begin
            rob_pop = 1'b1;
          end else if (fl_push_ready) begin
            rob_pop       = 1'b1;
            fl_push_valid = 1'b1;
            fl_push_prn   = sq_free.prn;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Architectural RAT: updated only by committing entries; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_A_REGS; i++) arat[i] <= arat_reset(arn_t'(i));
    end else if ((state == RUN) && rob_pop && run_free.valid) begin
      arat[rob_head.rd_arch] <= rob_head.p_new;
    end
  end

  // Registered commit trace, exception report and RAT restore beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_arch  <= '0;
      commit_prn   <= '0;
      exc_valid    <= 1'b0;
      exc_pc       <= '0;
      rest_valid   <= 1'b0;
      rest_arch    <= '0;
      rest_prn     <= '0;
    end else begin
      commit_valid <= (state == RUN) && rob_pop;
      commit_arch  <= rob_head.rd_arch;
      commit_prn   <= rob_head.p_new;
      exc_valid    <= exc_detect;
      if (exc_detect) exc_pc <= rob_head.pc;
      rest_valid   <= (state == RESTORE);
      rest_arch    <= cnt;
      rest_prn     <= arat[cnt];
    end
  end

endmodule

// File: tb/tb_retire_unit.sv
// Bench for retire_unit: directed scenarios followed by randomized episodes
// scored against a transaction-level model of commit/squash/restore.
module tb_retire_unit;
  import cpu_design_params::*;

  // ---------------- clock / reset / DUT ----------------
  logic      clk = 1'b0;
  logic      rst;
  logic      rob_head_valid;
  rob_data_t rob_head;
  logic      rob_pop;
  logic      fl_push_valid;
  prn_t      fl_push_prn;
  logic      fl_push_ready;
  logic      flush;
  logic      exc_valid;
  pc_t       exc_pc;
  logic      rest_valid;
  arn_t      rest_arch;
  prn_t      rest_prn;
  logic      commit_valid;
  arn_t      commit_arch;
  prn_t      commit_prn;

  always #5 clk = ~clk;

  retire_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rob_head_valid (rob_head_valid),
    .rob_head       (rob_head),
    .rob_pop        (rob_pop),
    .fl_push_valid  (fl_push_valid),
    .fl_push_prn    (fl_push_prn),
    .fl_push_ready  (fl_push_ready),
    .flush          (flush),
    .exc_valid      (exc_valid),
    .exc_pc         (exc_pc),
    .rest_valid     (rest_valid),
    .rest_arch      (rest_arch),
    .rest_prn       (rest_prn),
    .commit_valid   (commit_valid),
    .commit_arch    (commit_arch),
    .commit_prn     (commit_prn)
  );

  // ---------------- bench state / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  rob_data_t rob_q[$];
  rob_data_t drv_tmp;
  logic      pop_flag  = 1'b0;
  bit        rand_mode = 1'b0;
  bit        mon_en    = 1'b0;
  logic      ready_cmd = 1'b1;

  prn_t arat_m [NUM_A_REGS];
  logic [PRN_W-1:0]       exp_push_q[$];
  logic [ARN_W+PRN_W-1:0] exp_commit_q[$];
  logic [ARN_W+PRN_W-1:0] exp_rest_q[$];
  logic [PC_W-1:0]        exp_exc_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic rob_data_t mk(input logic done, input logic exc, input logic wr,
                                   input int rd, input int pn, input int po, input logic [31:0] pc);
    rob_data_t e;
    e           = '0;
    e.valid     = 1'b1;
    e.done      = done;
    e.exception = exc;
    e.writes_rd = wr;
    e.rd_arch   = arn_t'(rd);
    e.p_new     = prn_t'(pn);
    e.p_old     = prn_t'(po);
    e.pc        = pc;
    return e;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < NUM_A_REGS; a++) arat_m[a] = prn_t'(a);
  endtask

  // ---------------- ROB / free-list driver ----------------
  always @(negedge clk) pop_flag = rob_pop && !rst;

  always @(posedge clk) begin
    if (pop_flag && rob_q.size() > 0) rob_q.delete(0);
    #1;
    if (rand_mode) begin
      fl_push_ready = ($urandom_range(0, 3) != 0);
      if (rob_q.size() > 0 && !rob_q[0].done && $urandom_range(0, 2) == 0) begin
        drv_tmp      = rob_q[0];
        drv_tmp.done = 1'b1;
        rob_q[0]     = drv_tmp;
      end
    end else begin
      fl_push_ready = ready_cmd;
    end
    rob_head_valid = (rob_q.size() > 0);
    rob_head       = (rob_q.size() > 0) ? rob_q[0] : '0;
  end

  // ---------------- monitor for random episodes ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (fl_push_valid && fl_push_ready) begin
        check("push_expected", 64'(exp_push_q.size() > 0), 1);
        if (exp_push_q.size() > 0) check("push_prn", fl_push_prn, exp_push_q.pop_front());
      end
      if (commit_valid) begin
        check("commit_expected", 64'(exp_commit_q.size() > 0), 1);
        if (exp_commit_q.size() > 0) check("commit", {commit_arch, commit_prn}, exp_commit_q.pop_front());
      end
      if (rest_valid) begin
        check("rest_expected", 64'(exp_rest_q.size() > 0), 1);
        if (exp_rest_q.size() > 0) check("rest", {rest_arch, rest_prn}, exp_rest_q.pop_front());
      end
      if (exc_valid) begin
        check("exc_expected", 64'(exp_exc_q.size() > 0), 1);
        if (exp_exc_q.size() > 0) check("exc_pc", exc_pc, exp_exc_q.pop_front());
      end
      // Outside a squash the head must stall or retire by the eligibility rules.
      if (!flush && rob_head_valid) begin
        if (!rob_head.done || rob_head.exception) check("run_no_pop", rob_pop, 0);
        else if (!(rob_head.writes_rd && rob_head.rd_arch != 0) || fl_push_ready)
          check("run_pop", rob_pop, 1);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic expect_restore(input string tag);
    int c;
    c = 0;
    while (!rest_valid && c < 80) begin
      @(negedge clk);
      c++;
    end
    for (int a = 0; a < NUM_A_REGS; a++) begin
      check({tag, "_valid"}, rest_valid, 1);
      check({tag, "_arch"}, rest_arch, 64'(a));
      check({tag, "_prn"}, rest_prn, arat_m[a]);
      @(negedge clk);
    end
    check({tag, "_flush_end"}, flush, 0);
    check({tag, "_valid_end"}, rest_valid, 0);
  endtask

  // One batch of random entries, optionally with one exception; the model
  // derives every push, commit, exception and restore beat from the batch.
  task automatic run_episode(input int n, input int exc_at);
    rob_data_t e;
    bit        frees;
    int        c;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      e = mk(1'($urandom_range(0, 1)), (i == exc_at), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 31), $urandom_range(0, 47), $urandom_range(0, 47), $urandom);
      frees = e.writes_rd && (e.rd_arch != 0);
      if (exc_at < 0 || i < exc_at) begin
        exp_commit_q.push_back({e.rd_arch, e.p_new});
        if (frees) begin
          exp_push_q.push_back(e.p_old);
          arat_m[e.rd_arch] = e.p_new;
        end
      end else begin
        if (i == exc_at) exp_exc_q.push_back(e.pc);
        if (frees) exp_push_q.push_back(e.p_new);
      end
      rob_q.push_back(e);
    end
    if (exc_at >= 0)
      for (int a = 0; a < NUM_A_REGS; a++) exp_rest_q.push_back({arn_t'(a), arat_m[a]});
    c = 0;
    while (c < 1000 && (rob_q.size() > 0 || exp_push_q.size() > 0 || exp_commit_q.size() > 0 ||
                        exp_rest_q.size() > 0 || exp_exc_q.size() > 0 || flush)) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    check("drain_rob", rob_q.size(), 0);
    check("drain_push", exp_push_q.size(), 0);
    check("drain_commit", exp_commit_q.size(), 0);
    check("drain_rest", exp_rest_q.size(), 0);
    check("drain_exc", exp_exc_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int c;
    rst            = 1'b1;
    rob_head_valid = 1'b0;
    rob_head       = '0;
    fl_push_ready  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pop", rob_pop, 0);
    check("rst_push", fl_push_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_exc_valid", exc_valid, 0);
    check("rst_exc_pc", exc_pc, 0);
    check("rst_rest_valid", rest_valid, 0);
    check("rst_commit_valid", commit_valid, 0);
    rst = 1'b0;

    // Simple freeing retire: pop and push the same cycle, trace next cycle.
    @(negedge clk);
    ready_cmd = 1'b1;
    rob_q.push_back(mk(1, 0, 1, 5, 33, 5, 32'h100));
    @(negedge clk);
    check("d1_pop", rob_pop, 1);
    check("d1_push_valid", fl_push_valid, 1);
    check("d1_push_prn", fl_push_prn, 5);
    @(negedge clk);
    check("d1_commit_valid", commit_valid, 1);
    check("d1_commit_arch", commit_arch, 5);
    check("d1_commit_prn", commit_prn, 33);
    check("d1_no_pop_empty", rob_pop, 0);
    arat_m[5] = 6'd33;

    // Head not done for 3 cycles, then done.
    rob_q.push_back(mk(0, 0, 1, 3, 20, 3, 32'h104));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("d2_stall", rob_pop, 0);
    end
    drv_tmp      = rob_q[0];
    drv_tmp.done = 1'b1;
    rob_q[0]     = drv_tmp;
    @(negedge clk);
    check("d2_pop", rob_pop, 1);
    arat_m[3] = 6'd20;

    // r0 destination: pop without a push.
    rob_q.push_back(mk(1, 0, 1, 0, 9, 0, 32'h108));
    @(negedge clk);
    check("d3_r0_pop", rob_pop, 1);
    check("d3_r0_no_push", fl_push_valid, 0);

    // Freeing head with the free list full: no pop until ready.
    ready_cmd = 1'b0;
    rob_q.push_back(mk(1, 0, 1, 7, 34, 7, 32'h10c));
    @(negedge clk);
    check("d3_notready_pop", rob_pop, 0);
    @(negedge clk);
    check("d3_notready_pop", rob_pop, 0);
    ready_cmd = 1'b1;
    @(negedge clk);
    check("d3_ready_pop", rob_pop, 1);
    check("d3_ready_push", fl_push_prn, 7);
    arat_m[7] = 6'd34;
    @(negedge clk);

    // 16 back-to-back retires, no bubbles.
    for (int i = 0; i < ROB_SIZE; i++) rob_q.push_back(mk(1, 0, 1, i + 1, 16 + i, i + 1, 32'h200 + 4 * i));
    for (int i = 0; i < ROB_SIZE; i++) begin
      @(negedge clk);
      check("d6_pop", rob_pop, 1);
      check("d6_push_prn", fl_push_prn, 64'(i + 1));
      if (i > 0) check("d6_commit_prn", commit_prn, 64'(16 + i - 1));
      arat_m[i + 1] = prn_t'(16 + i);
    end
    @(negedge clk);
    check("d6_commit_last", commit_prn, 31);
    check("d6_drained", rob_pop, 0);

    // Exception with two younger entries.
    rob_q.push_back(mk(1, 1, 1, 1, 40, 1, 32'h1000));
    rob_q.push_back(mk(0, 0, 1, 2, 41, 2, 32'h1004));
    rob_q.push_back(mk(1, 0, 1, 3, 42, 3, 32'h1008));
    @(negedge clk);
    check("d4_exc_no_pop", rob_pop, 0);
    check("d4_flush_pre", flush, 0);
    @(negedge clk);
    check("d4_exc_valid", exc_valid, 1);
    check("d4_exc_pc", exc_pc, 32'h1000);
    check("d4_flush", flush, 1);
    check("d4_sq_push40", {fl_push_valid, fl_push_prn}, {1'b1, 6'd40});
    @(negedge clk);
    check("d4_exc_pulse", exc_valid, 0);
    check("d4_sq_push41", {fl_push_valid, fl_push_prn}, {1'b1, 6'd41});
    @(negedge clk);
    check("d4_sq_push42", {fl_push_valid, fl_push_prn}, {1'b1, 6'd42});
    expect_restore("d4_rest");
    check("d4_exc_pc_held", exc_pc, 32'h1000);

    // Reset in the middle of RESTORE, then a fresh exception restores identity.
    rob_q.push_back(mk(1, 1, 1, 4, 44, 4, 32'h2000));
    c = 0;
    while (!(rest_valid && rest_arch == 5'd10) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("d5_reached_beat10", rest_valid, 1);
    rst = 1'b1;
    #1;
    check("d5_rst_flush", flush, 0);
    check("d5_rst_rest_valid", rest_valid, 0);
    check("d5_rst_exc_pc", exc_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rob_q.push_back(mk(1, 1, 0, 6, 45, 6, 32'h3000));
    expect_restore("d5_rest_identity");
    check("d5_exc_pc", exc_pc, 32'h3000);

    // Randomized episodes against the model.
    mon_en    = 1'b1;
    rand_mode = 1'b1;
    for (int ep = 0; ep < 40; ep++) begin
      int n;
      int exc_at;
      n      = $urandom_range(1, ROB_SIZE);
      exc_at = ($urandom_range(0, 1) != 0) ? $urandom_range(0, n - 1) : -1;
      run_episode(n, exc_at);
    end
    mon_en    = 1'b0;
    rand_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
